// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - state encoding and address-width helpers for dcache_wt
package dcache_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REFILL = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_REFILL = ST_REFILL,
    S_WRITE  = ST_WRITE
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic int woff_w(input int line_words);
    return clog2(line_words);
  endfunction

  // The beat counter keeps one bit even for single-word lines.
  function automatic int cnt_w(input int line_words);
    return (line_words > 1) ? clog2(line_words) : 1;
  endfunction

  function automatic int idx_w(input int sets);
    return clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets, input int line_words);
    return addr_w - 2 - clog2(line_words) - clog2(sets);
  endfunction

endpackage

// File: rtl/dcache_stats.sv
// rtl/dcache_stats.sv - saturating hit/miss/write counters, built only with DCACHE_STATS_EN
module dcache_stats (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_hit,
  input  logic        i_miss,
  input  logic        i_write,
  output logic [31:0] o_hits,
  output logic [31:0] o_misses,
  output logic [31:0] o_writes
);

  logic [31:0] r_hits;
  logic [31:0] r_misses;
  logic [31:0] r_writes;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hits   <= '0;
      r_misses <= '0;
      r_writes <= '0;
    end else begin
      if (i_hit && (r_hits != '1))     r_hits   <= r_hits + 32'd1;
      if (i_miss && (r_misses != '1))  r_misses <= r_misses + 32'd1;
      if (i_write && (r_writes != '1)) r_writes <= r_writes + 32'd1;
    end
  end

  assign o_hits   = r_hits;
  assign o_misses = r_misses;
  assign o_writes = r_writes;

endmodule

// File: rtl/dcache_wt.sv
// rtl/dcache_wt.sv - blocking direct-mapped write-through no-write-allocate data cache
// Define DCACHE_STATS_EN to add the stat_hits/stat_misses/stat_writes counters.
module dcache_wt
  import dcache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        byte_en,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic [3:0]        mem_wr_be,
  input  logic              mem_wr_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
  output logic [31:0]       stat_writes
`endif
);

  localparam int WOFF_W  = woff_w(LINE_WORDS);
  localparam int CNT_W   = cnt_w(LINE_WORDS);
  localparam int IDX_W   = idx_w(SETS);
  localparam int TAG_W   = tag_w(ADDR_W, SETS, LINE_WORDS);
  localparam int IDX_LSB = 2 + WOFF_W;
  localparam int TAG_LSB = IDX_LSB + IDX_W;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * 4 - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ADDR_W'(3);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  state_t            r_state;
  state_t            w_next;
  logic [SETS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [DATA_W-1:0] r_data [SETS][LINE_WORDS];
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [3:0]        r_wr_be;

  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  w_ref_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [TAG_W-1:0]  w_ref_tag;
  logic [CNT_W-1:0]  w_woff;
  logic              w_hit;
  logic              w_ready;
  logic              w_beat;
  logic              w_last_beat;
  logic              w_store_hit;
  logic [DATA_W-1:0] w_rdata;

  assign w_idx     = addr[IDX_LSB +: IDX_W];
  assign w_tag     = addr[TAG_LSB +: TAG_W];
  // Refill targets the latched line address so the fill never depends on the live inputs.
  assign w_ref_idx = r_rd_addr[IDX_LSB +: IDX_W];
  assign w_ref_tag = r_rd_addr[TAG_LSB +: TAG_W];

  generate
    if (LINE_WORDS > 1) begin : g_woff
      assign w_woff = addr[2 +: WOFF_W];
    end else begin : g_woff_single
      assign w_woff = '0;
    end
  endgenerate

  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_beat      = (r_state == S_REFILL) && mem_rd_valid;
  assign w_last_beat = (r_cnt == LAST_BEAT);
  assign w_store_hit = (r_state == S_IDLE) && req_valid && we && (byte_en != 4'd0) && w_hit;

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b1;
    w_rdata = '0;
    case (r_state)
      S_IDLE: begin
        if (req_valid && !we) begin
          if (w_hit) begin
            w_rdata = r_data[w_idx][w_woff];
          end else begin
            w_ready = 1'b0;
            w_next  = S_REFILL;
          end
        end else if (req_valid && we && (byte_en != 4'd0)) begin
          w_ready = 1'b0;
          w_next  = S_WRITE;
        end
      end
      S_REFILL: begin
        w_ready = 1'b0;
        if (mem_rd_valid && w_last_beat) w_next = S_IDLE;
      end
      S_WRITE: begin
        w_ready = mem_wr_ack;
        if (mem_wr_ack) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_valid   <= '0;
      r_cnt     <= '0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_be   <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && (w_next == S_REFILL)) r_rd_addr <= addr & ~LINE_MASK;
      if ((r_state == S_IDLE) && (w_next == S_WRITE)) begin
        r_wr_addr <= addr & ~WORD_MASK;
        r_wr_data <= wdata;
        r_wr_be   <= byte_en;
      end
      if (w_beat) begin
        if (w_last_beat) begin
          r_cnt              <= '0;
          r_valid[w_ref_idx] <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (w_beat) begin
      r_data[w_ref_idx][r_cnt] <= mem_rd_data;
      if (w_last_beat) r_tag[w_ref_idx] <= w_ref_tag;
    end
    if (w_store_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) r_data[w_idx][w_woff][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata       = w_rdata;
  assign ready       = w_ready | ~rst;
  assign mem_rd_req  = (r_state == S_REFILL);
  assign mem_rd_addr = r_rd_addr;
  assign mem_wr_req  = (r_state == S_WRITE);
  assign mem_wr_addr = r_wr_addr;
  assign mem_wr_data = r_wr_data;
  assign mem_wr_be   = r_wr_be;

`ifdef DCACHE_STATS_EN
  logic w_cnt_hit;
  logic w_cnt_miss;
  logic w_cnt_write;

  assign w_cnt_hit   = (r_state == S_IDLE) && req_valid && !we && w_hit;
  assign w_cnt_miss  = (r_state == S_IDLE) && (w_next == S_REFILL);
  assign w_cnt_write = (r_state == S_WRITE) && mem_wr_ack;

  dcache_stats u_stats (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_hit    (w_cnt_hit),
    .i_miss   (w_cnt_miss),
    .i_write  (w_cnt_write),
    .o_hits   (stat_hits),
    .o_misses (stat_misses),
    .o_writes (stat_writes)
  );
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// tb/tb_dcache_wt.sv - self-checking bench for dcache_wt against a memory-level cache model
module tb_dcache_wt;

  localparam int SETS = 64;
  localparam int LW   = 4;
  localparam logic [31:0] LMASK = 32'(LW * 4 - 1);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, we;
  logic [31:0] addr, wdata;
  logic [3:0]  byte_en;
  logic [31:0] rdata;
  logic        ready;
  logic        mem_rd_req, mem_rd_valid;
  logic [31:0] mem_rd_addr, mem_rd_data;
  logic        mem_wr_req, mem_wr_ack;
  logic [31:0] mem_wr_addr, mem_wr_data;
  logic [3:0]  mem_wr_be;
`ifdef DCACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_writes;
`endif

  always #5 clk = ~clk;

  dcache_wt #(.ADDR_W(32), .DATA_W(32), .SETS(SETS), .LINE_WORDS(LW)) dut (
    .clk          (clk),
    .rst          (rst_n),
    .req_valid    (req_valid),
    .we           (we),
    .addr         (addr),
    .wdata        (wdata),
    .byte_en      (byte_en),
    .rdata        (rdata),
    .ready        (ready),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_req   (mem_wr_req),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_be    (mem_wr_be),
    .mem_wr_ack   (mem_wr_ack)
`ifdef DCACHE_STATS_EN
    ,
    .stat_hits    (stat_hits),
    .stat_misses  (stat_misses),
    .stat_writes  (stat_writes)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  int exp_hits = 0, exp_misses = 0, exp_writes = 0;
  int ack_delay = 1;
  int beat = 0;
  int wcnt = 0;
  bit rd_started = 0;

  logic [31:0] mem    [int unsigned];
  logic [31:0] m_line [int unsigned];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a >> 2)) return mem[a >> 2];
    return (a & ~32'd3) ^ 32'h5A5A0000;
  endfunction

  function automatic int unsigned line_idx(input logic [31:0] a);
    return (a / (LW * 4)) % SETS;
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_line.exists(line_idx(a)) && (m_line[line_idx(a)] == (a & ~LMASK));
  endfunction

  // Memory agent: one turnaround cycle, then one beat per cycle; write ack after ack_delay cycles.
  always begin
    logic [31:0] w;
    @(posedge clk);
    if (rst_n && mem_wr_req && mem_wr_ack) begin
      w = mem_rd(addr);
      for (int b = 0; b < 4; b++) if (byte_en[b]) w[8*b +: 8] = wdata[8*b +: 8];
      mem[addr >> 2] = w;
    end
    if (rst_n && mem_rd_valid && beat == LW) m_line[line_idx(addr)] = addr & ~LMASK;
    #1;
    if (!rst_n || !mem_rd_req) begin
      mem_rd_valid = 1'b0; beat = 0; rd_started = 1'b0;
    end else if (!rd_started) begin
      rd_started = 1'b1; mem_rd_valid = 1'b0;
    end else if (beat < LW) begin
      mem_rd_valid = 1'b1; mem_rd_data = mem_rd(mem_rd_addr + 32'(beat * 4)); beat++;
    end else begin
      mem_rd_valid = 1'b0;
    end
    if (rst_n && mem_wr_req) begin
      wcnt++; mem_wr_ack = (wcnt == ack_delay);
    end else begin
      wcnt = 0; mem_wr_ack = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      m_line.delete();
      check("rst_ready", ready, 1);
      check("rst_rd_req", mem_rd_req, 0);
      check("rst_wr_req", mem_wr_req, 0);
      check("rst_rdata", rdata, 0);
      check("rst_rd_addr", mem_rd_addr, 0);
      check("rst_wr_addr", mem_wr_addr, 0);
      check("rst_wr_data", mem_wr_data, 0);
      check("rst_wr_be", mem_wr_be, 0);
    end else if (!req_valid) begin
      check("idle_ready", ready, 1);
    end else if (!we) begin
      check("ld_ready", ready, m_hit(addr));
      check("ld_wr_req", mem_wr_req, 0);
      if (ready) check("ld_rdata", rdata, mem_rd(addr));
      if (ready) check("ld_rd_req_done", mem_rd_req, 0);
      if (mem_rd_req) check("rd_addr", mem_rd_addr, addr & ~LMASK);
    end else begin
      check("st_ready", ready, (byte_en == 4'd0) || mem_wr_ack);
      check("st_rd_req", mem_rd_req, 0);
      if (byte_en == 4'd0) check("st_noop_wr_req", mem_wr_req, 0);
      if (mem_wr_req) begin
        check("wr_addr", mem_wr_addr, addr & ~32'd3);
        check("wr_data", mem_wr_data, wdata);
        check("wr_be", mem_wr_be, byte_en);
      end
    end
  end

  task automatic do_load(input logic [31:0] a, output logic [31:0] d, output int lat);
    req_valid = 1'b1; we = 1'b0; addr = a; byte_en = 4'd0; wdata = '0;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (i == 0 && !ready) exp_misses++;
      if (ready) break;
    end
    check("ld_done", ready, 1);
    d = rdata;
    exp_hits++;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          output int lat);
    req_valid = 1'b1; we = 1'b1; addr = a; wdata = d; byte_en = be;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (ready) break;
    end
    check("st_done", ready, 1);
    if (be != 4'd0) exp_writes++;
    @(posedge clk); #1;
    req_valid = 1'b0; we = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int lat;
    bit found;
    mem[32'h100 >> 2] = 32'hA0A0A0A0;
    mem[32'h104 >> 2] = 32'hA1A1A1A1;
    mem[32'h108 >> 2] = 32'hA2A2A2A2;
    mem[32'h10C >> 2] = 32'hA3A3A3A3;
    mem_rd_valid = 1'b0; mem_rd_data = '0; mem_wr_ack = 1'b0;
    rst_n = 1'b0; req_valid = 1'b1; we = 1'b0; addr = 32'h100; wdata = '0; byte_en = 4'd0;
    repeat (3) @(posedge clk);
    #2; req_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;

    do_load(32'h100, d, lat);
    check("miss_lat_0x100", lat, 7);
    check("ld_0x100", d, 32'hA0A0A0A0);
    do_load(32'h10C, d, lat);
    check("hit_lat_0x10C", lat, 1);
    check("ld_0x10C", d, 32'hA3A3A3A3);

    ack_delay = 3;
    do_store(32'h104, 32'h11223344, 4'b0011, lat);
    check("st_lat_ack3", lat, 4);
    check("mem_0x104", mem_rd(32'h104), 32'hA1A13344);
    do_load(32'h104, d, lat);
    check("hit_lat_0x104", lat, 1);
    check("ld_0x104_merged", d, 32'hA1A13344);

    ack_delay = 1;
    do_store(32'h2000, 32'hDEADBEEF, 4'hF, lat);
    check("st_miss_lat", lat, 2);
    do_load(32'h2000, d, lat);
    check("no_alloc_miss_lat", lat, 7);
    check("ld_0x2000", d, 32'hDEADBEEF);

    do_store(32'h108, 32'hFFFFFFFF, 4'h0, lat);
    check("st_be0_lat", lat, 1);
    do_load(32'h108, d, lat);
    check("ld_0x108_untouched", d, 32'hA2A2A2A2);

    req_valid = 1'b1; we = 1'b0; addr = 32'h300; byte_en = 4'd0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (mem_rd_valid && beat == 3) begin found = 1'b1; break; end
    end
    check("beat2_reached", found, 1);
    rst_n = 1'b0;
    exp_hits = 0; exp_misses = 0; exp_writes = 0;
    #1;
    check("rst_abort_rd_req", mem_rd_req, 0);
    check("rst_abort_ready", ready, 1);
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;

    do_load(32'h300, d, lat);
    check("rearm_miss_lat", lat, 7);
    check("ld_0x300", d, 32'h5A5A0300);
    do_load(32'h304, d, lat);
    check("ld_0x304", d, 32'h5A5A0304);
    do_load(32'h30C, d, lat);
    check("hit_lat_0x30C", lat, 1);
    do_store(32'h300, 32'h01020304, 4'hF, lat);
    do_store(32'h308, 32'h000000EE, 4'b0001, lat);
`ifdef DCACHE_STATS_EN
    check("stat_hits", stat_hits, 3);
    check("stat_misses", stat_misses, 1);
    check("stat_writes", stat_writes, 2);
    check("stat_hits_model", stat_hits, exp_hits);
    check("stat_misses_model", stat_misses, exp_misses);
    check("stat_writes_model", stat_writes, exp_writes);
`endif
    do_load(32'h308, d, lat);
    check("ld_0x308_merged", d, 32'h5A5A03EE);
    do_load(32'h300, d, lat);
    check("ld_0x300_full", d, 32'h01020304);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1);
  end

endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Parametrised, blocking, direct-mapped, write-through, no-write-allocate data cache for the MEM stage. Successor to the fixed single-word DCache.
- Adds configurable sets and line size, byte-enable stores, and a multi-beat refill handshake with a real write-acknowledge path to memory.
- The MEM stage drives `mem_stall = ~ready`.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, word width; must be 32 (4 byte lanes)
- SETS, 64, number of lines; power of 2, ≥2
- LINE_WORDS, 4, words per line; power of 2, ≥1

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  MEM-stage access present (load or store)
- we  in  1  1 = store, 0 = load
- addr  in  ADDR_W  byte address; bits [1:0] ignored
- wdata  in  32  store data, already forwarded
- byte_en  in  4  store byte lanes; ignored on loads
- rdata  out  32  load data, valid when ready & req_valid & ~we
- ready  out  1  access completes this cycle
- mem_rd_req  out  1  line refill request, held until the last beat
- mem_rd_addr  out  ADDR_W  line-aligned refill address
- mem_rd_valid  in  1  one refill beat per cycle when high, words in order 0..LINE_WORDS-1
- mem_rd_data  in  32  refill beat data
- mem_wr_req  out  1  write-through request, held until ack
- mem_wr_addr  out  ADDR_W  word-aligned store address
- mem_wr_data  out  32  store data
- mem_wr_be  out  4  store byte enables
- mem_wr_ack  in  1  memory accepted the write

Behaviour:
- Address split, LSB first: byte offset (2 bits), word offset (log2 LINE_WORDS), index (log2 SETS), tag (remainder).
- Storage:
  - valid bit per set, in flops reset to 0.
  - Tag and data arrays are not reset.
- FSM states: IDLE, REFILL, WRITE.
- On reset:
  - state = IDLE; all valid bits = 0; beat counter = 0.
  - mem_rd_req = 0, mem_wr_req = 0; mem_* addr/data/be = 0.
  - rdata = 0. ready = 1, since req_valid is don't-care while in reset.
- IDLE:
  - No req_valid → ready = 1.
  - Load hit → rdata = addressed word combinationally; ready = 1; zero-cycle latency.
  - Load miss → ready = 0. Next cycle: REFILL with mem_rd_req = 1 and mem_rd_addr = line address.
  - Store with byte_en == 0 → no-op, ready = 1.
  - Store with nonzero byte_en:
    - On hit, merge the enabled bytes into the line at the clock edge.
    - On miss, the cache is not modified.
    - Either way ready = 0; latch address/data/be; go to WRITE.
- REFILL:
  - Each mem_rd_valid writes one word at the beat counter and increments it.
  - On the last beat: set tag and valid, counter → 0, mem_rd_req → 0, go to IDLE.
  - ready stays 0 throughout. The held request re-looks up in IDLE and hits.
  - Total load-miss latency = LINE_WORDS + 2 cycles, given mem_rd_valid every cycle.
  - mem_rd_valid outside REFILL is ignored.
- WRITE:
  - mem_wr_req = 1 with the latched fields, stable until ack.
  - On the mem_wr_ack cycle: ready = 1 combinationally, mem_wr_req drops next cycle, return to IDLE.
  - Minimum store latency is 2 cycles (IDLE then the WRITE ack cycle).
- Reset asserted mid-REFILL or mid-WRITE: the transaction is abandoned immediately; the partial line is never marked valid.
- LINE_WORDS = 1: the beat counter has width 1 and is never used beyond 0; refill is a single beat.
- Inputs must be held stable while ready = 0. This is the pipeline's responsibility; the cache does not re-sample them except as latched for WRITE.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined:
  - Extra outputs stat_hits, stat_misses, stat_writes (32 bits each).
  - Counted on each ready-completing load hit, each REFILL entry, and each acked store.
  - Saturating at all-ones; cleared by rst.
- When undefined: the outputs and counters are absent; no other behaviour changes.

Decomposition:
- Package dcache_pkg holds:
  - state encoding localparams (IDLE = 0, REFILL = 1, WRITE = 2);
  - a clog2 function;
  - derived width helpers (offset/index/tag width from ADDR_W, SETS, LINE_WORDS).
- Natural sub-module: dcache_stats, the saturating counter bank, instantiated only under DCACHE_STATS_EN.
- Byte-merge logic stays inline.

Test Plan:
- Reset, then load 0x100 with memory returning 0xA0..0xA3 over 4 beats → ready low 6 cycles, then rdata = 0xA0; a following load 0x10C hits in 0 cycles → 0xA3.
- Store 0x104, data 0x11223344, be = 4'b0011, after the line is cached; ack 3 cycles later → mem_wr_* stable until ack; later load 0x104 = 0xA1A13344 (original word 0xA1A1A1A1).
- Store miss to 0x2000 with be = 4'hF → memory write issued; next load 0x2000 misses (no allocate) and triggers a refill.
- Store with be = 0 → ready = 1 the same cycle, mem_wr_req never asserts.
- Assert rst during beat 2 of a refill → mem_rd_req = 0 immediately; a re-issued load to the same address misses again.
- DCACHE_STATS_EN: 3 hits, 1 miss, 2 stores → stat_hits = 3, stat_misses = 1, stat_writes = 2.
